// File: rtl/rom_boot_arbiter_if.sv
// rtl/rom_boot_arbiter_if.sv - request/response channels of both boot ROM ports
interface rom_boot_arbiter_if;
  logic        req_valid_0;
  logic        req_valid_1;
  logic [15:0] req_addr_0;
  logic [15:0] req_addr_1;
  logic        req_ready_0;
  logic        req_ready_1;
  logic        rsp_valid_0;
  logic        rsp_valid_1;
  logic [31:0] rsp_data_0;
  logic [31:0] rsp_data_1;
  logic        rsp_err_0;
  logic        rsp_err_1;
  logic        rsp_ready_0;
  logic        rsp_ready_1;

  modport master (
    output req_valid_0, req_valid_1, req_addr_0, req_addr_1,
    output rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1,
    input  rsp_err_0, rsp_err_1
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_addr_0, req_addr_1,
    input  rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1,
    output rsp_err_0, rsp_err_1
  );
endinterface

// File: rtl/rom_boot_arbiter.sv
// rtl/rom_boot_arbiter.sv - round-robin two-port arbiter for the boot ROM read port
module rom_boot_arbiter #(
  parameter logic [15:0] ADDR_LIMIT = 16'h1000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  rom_boot_arbiter_if.slave        bus,
  output logic [15:0]              rom_address,
  input  logic [31:0]              rom_out
);

  logic        last_grant;
  logic        elig_0;
  logic        elig_1;
  logic        grant_0;
  logic        grant_1;
  logic        acc_err;
  logic [31:0] acc_data;

  // A slot is free when empty or being drained this very cycle.
  assign elig_0 = bus.req_valid_0 && (!bus.rsp_valid_0 || bus.rsp_ready_0);
  assign elig_1 = bus.req_valid_1 && (!bus.rsp_valid_1 || bus.rsp_ready_1);

  assign grant_0 = elig_0 && (!elig_1 || last_grant);
  assign grant_1 = elig_1 && (!elig_0 || !last_grant);

  assign bus.req_ready_0 = grant_0;
  assign bus.req_ready_1 = grant_1;

  always_comb begin
    rom_address = 16'h0000;
    if (grant_0) begin
      rom_address = bus.req_addr_0;
    end else if (grant_1) begin
      rom_address = bus.req_addr_1;
    end
  end

  // No wrap-around: any address at or past the limit is an error.
  assign acc_err  = (rom_address[1:0] != 2'b00) || (rom_address >= ADDR_LIMIT);
  assign acc_data = acc_err ? 32'h0000_0000 : rom_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant      <= 1'b1;
      bus.rsp_valid_0 <= 1'b0;
      bus.rsp_valid_1 <= 1'b0;
      bus.rsp_data_0  <= 32'h0000_0000;
      bus.rsp_data_1  <= 32'h0000_0000;
      bus.rsp_err_0   <= 1'b0;
      bus.rsp_err_1   <= 1'b0;
    end else begin
      if (grant_0) begin
        last_grant <= 1'b0;
      end else if (grant_1) begin
        last_grant <= 1'b1;
      end

      if (grant_0) begin
        bus.rsp_valid_0 <= 1'b1;
        bus.rsp_data_0  <= acc_data;
        bus.rsp_err_0   <= acc_err;
      end else if (bus.rsp_valid_0 && bus.rsp_ready_0) begin
        bus.rsp_valid_0 <= 1'b0;
      end

      if (grant_1) begin
        bus.rsp_valid_1 <= 1'b1;
        bus.rsp_data_1  <= acc_data;
        bus.rsp_err_1   <= acc_err;
      end else if (bus.rsp_valid_1 && bus.rsp_ready_1) begin
        bus.rsp_valid_1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_boot_arbiter.sv
// tb/tb_rom_boot_arbiter.sv - table-driven scoreboard bench for rom_boot_arbiter
module tb_rom_boot_arbiter;

  typedef struct {
    logic        v0;
    logic [15:0] a0;
    logic        r0;
    logic        v1;
    logic [15:0] a1;
    logic        r1;
    logic        g0;
    logic        g1;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] rom_address;
  logic [31:0] rom_out;

  rom_boot_arbiter_if bus ();

  rom_boot_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .rom_address (rom_address),
    .rom_out     (rom_out)
  );

  assign rom_out = {16'hA5A5, rom_address};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  rsp_t q0[$];
  rsp_t q1[$];
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [15:0] a0, input logic r0,
                              input logic v1, input logic [15:0] a1, input logic r1,
                              input logic g0, input logic g1);
    vec_t t;
    t.v0 = v0; t.a0 = a0; t.r0 = r0;
    t.v1 = v1; t.a1 = a1; t.r1 = r1;
    t.g0 = g0; t.g1 = g1;
    return t;
  endfunction

  function automatic rsp_t expect_rsp(input logic [15:0] addr);
    rsp_t e;
    e.err  = (addr[1:0] != 2'b00) || (addr >= 16'h1000);
    e.data = e.err ? 32'h0 : {16'hA5A5, addr};
    return e;
  endfunction

  // Called #1 after a rising edge: drive, check at the falling edge, advance.
  task automatic cycle(input vec_t t);
    rsp_t e;
    bus.req_valid_0 = t.v0; bus.req_addr_0 = t.a0; bus.rsp_ready_0 = t.r0;
    bus.req_valid_1 = t.v1; bus.req_addr_1 = t.a1; bus.rsp_ready_1 = t.r1;
    @(negedge clk);
    chk("req_ready_0", {31'h0, bus.req_ready_0}, {31'h0, t.g0});
    chk("req_ready_1", {31'h0, bus.req_ready_1}, {31'h0, t.g1});
    chk("rom_address", {16'h0, rom_address},
        {16'h0, t.g0 ? t.a0 : (t.g1 ? t.a1 : 16'h0000)});

    chk("rsp_valid_0", {31'h0, bus.rsp_valid_0}, {31'h0, (q0.size() != 0)});
    if (bus.rsp_valid_0 && q0.size() != 0) begin
      e = bus.rsp_ready_0 ? q0.pop_front() : q0[0];
      chk("rsp_data_0", bus.rsp_data_0, e.data);
      chk("rsp_err_0", {31'h0, bus.rsp_err_0}, {31'h0, e.err});
    end
    chk("rsp_valid_1", {31'h0, bus.rsp_valid_1}, {31'h0, (q1.size() != 0)});
    if (bus.rsp_valid_1 && q1.size() != 0) begin
      e = bus.rsp_ready_1 ? q1.pop_front() : q1[0];
      chk("rsp_data_1", bus.rsp_data_1, e.data);
      chk("rsp_err_1", {31'h0, bus.rsp_err_1}, {31'h0, e.err});
    end

    if (t.g0) q0.push_back(expect_rsp(t.a0));
    if (t.g1) q1.push_back(expect_rsp(t.a1));
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.req_valid_0 = 1'b0; bus.req_addr_0 = 16'h0; bus.rsp_ready_0 = 1'b0;
    bus.req_valid_1 = 1'b0; bus.req_addr_1 = 16'h0; bus.rsp_ready_1 = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_rsp_valid_0", {31'h0, bus.rsp_valid_0}, 32'h0);
    chk("rst_rsp_valid_1", {31'h0, bus.rsp_valid_1}, 32'h0);
    chk("rst_rsp_data_0", bus.rsp_data_0, 32'h0);
    chk("rst_rsp_err_1", {31'h0, bus.rsp_err_1}, 32'h0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    vecs[1]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 16'h0004, 1'b1, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b1);
    vecs[3]  = mk(1'b1, 16'h0004, 1'b1, 1'b1, 16'h0008, 1'b1, 1'b1, 1'b0);
    vecs[4]  = mk(1'b1, 16'h0004, 1'b1, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b1);
    vecs[5]  = mk(1'b1, 16'h0004, 1'b1, 1'b1, 16'h0008, 1'b1, 1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 16'h0002, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 16'h0002, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b1, 1'b0);
    vecs[8]  = mk(1'b1, 16'h0002, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mk(1'b1, 16'h0002, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0FFC, 1'b1, 1'b0, 1'b1);
    vecs[11] = mk(1'b1, 16'hFFFC, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    bus.req_valid_0 = 1'b0; bus.req_addr_0 = 16'h0; bus.rsp_ready_0 = 1'b0;
    bus.req_valid_1 = 1'b0; bus.req_addr_1 = 16'h0; bus.rsp_ready_1 = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("init_rsp_valid_0", {31'h0, bus.rsp_valid_0}, 32'h0);
    chk("init_rsp_valid_1", {31'h0, bus.rsp_valid_1}, 32'h0);
    chk("init_rsp_data_1", bus.rsp_data_1, 32'h0);
    chk("init_rsp_err_0", {31'h0, bus.rsp_err_0}, 32'h0);
    chk("init_req_ready_0", {31'h0, bus.req_ready_0}, 32'h0);
    chk("init_rom_address", {16'h0, rom_address}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i]);
    end

    // Reset while port 0 holds an unconsumed response.
    cycle(mk(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0));
    chk("pre_reset_rsp_valid_0", {31'h0, bus.rsp_valid_0}, 32'h1);
    apply_reset();
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b0, 1'b1));
    cycle(mk(1'b1, 16'h0050, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0));
    // last_grant now points at port 0; reset must hand the next contention back to it.
    apply_reset();
    cycle(mk(1'b1, 16'h0044, 1'b1, 1'b1, 16'h0048, 1'b1, 1'b1, 1'b0));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0048, 1'b1, 1'b0, 1'b1));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_boot_arbiter.md
# rom_boot_arbiter

Two-port arbiter sharing the single combinational boot ROM read port (16-bit byte address, 32-bit word data) between the instruction-fetch path (port 0) and the data/loader path (port 1). Each port has a valid/ready request channel and a one-entry registered response channel. The arbiter grants at most one ROM access per cycle, checks the address range and word alignment, and returns data one cycle after acceptance. It sits between the core's fetch/load units and the ROM.

## Interface
- ADDR_LIMIT, 16'h1000, first byte address outside the ROM (1024 words × 4 bytes); addresses ≥ ADDR_LIMIT are errors
- clk  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid_0 / req_valid_1  input  1  port requests a ROM read
- req_addr_0 / req_addr_1  input  16  byte address; held stable while valid and not ready
- req_ready_0 / req_ready_1  output  1  request accepted this cycle (grant)
- rsp_valid_0 / rsp_valid_1  output  1  response slot holds data
- rsp_data_0 / rsp_data_1  output  32  read word (0 on error)
- rsp_err_0 / rsp_err_1  output  1  access was misaligned or out of range
- rsp_ready_0 / rsp_ready_1  input  1  port consumes the response this cycle
- rom_address  output  16  address driven to the ROM; 16'h0000 when no grant
- rom_out  input  32  combinational ROM data for rom_address, same cycle

## Operation
- Port i is eligible when req_valid_i=1 and its slot is free: rsp_valid_i=0, or rsp_valid_i=1 and rsp_ready_i=1 (drain and refill in the same cycle).
- Arbitration is round-robin on register last_grant. If both ports are eligible, the port that is not last_grant wins. If only one port is eligible, it wins. last_grant updates only on a grant.
- req_ready_i equals grant_i. It is combinational from req_valid and slot state. A requester's valid must not depend on ready.
- rom_address equals the granted port's req_addr. No grant: 16'h0000.
- Error check on the granted address: err = (addr[1:0]≠0) or (addr ≥ ADDR_LIMIT). On error, data captured is 32'h0 and err=1. Otherwise data is rom_out and err=0.
- On grant to port i at edge N: rsp_valid_i←1, rsp_data_i/rsp_err_i←captured values.
- On rsp_valid_i & rsp_ready_i with no new grant: rsp_valid_i←0. rsp_data_i and rsp_err_i hold their last values.
- Response slots are independent. A stalled port (rsp_ready=0) never blocks the other port.
- Responses per port are returned in request order. This is trivially true because each port has only one outstanding response.

## Timing
- Reset (async assert, synchronous-safe deassert by the system) sets:
  - rsp_valid_*=0, rsp_data_*=0, rsp_err_*=0
  - last_grant=1, so port 0 wins the first contention
  - req_ready_* and rom_address follow combinationally (0 while no request)
- Latency: request accepted at edge N; rsp_valid high from N+1 onward until consumed.
- Throughput: one grant per cycle total. A single port streams one word per cycle when rsp_ready is held at 1.
- Contention with both ports always eligible: grants alternate 0,1,0,1…
- Reset asserted mid-operation: pending responses are discarded immediately and last_grant returns to 1. A request that is being accepted in the same cycle is lost.
- Address 16'h0FFC is valid. 16'h1000 is an error. 16'hFFFC is an error (no wrap-around).

## Test plan
- Bench ROM model: rom_out = {16'hA5A5, rom_address}.
- Reset then single read: port 0 sends addr 16'h0010 with rsp_ready_0=1. Required: req_ready_0=1 in the same cycle; next cycle rsp_valid_0=1, rsp_data_0=32'hA5A50010, rsp_err_0=0.
- Contention: both ports valid every cycle with rsp_ready=1, port 0 addr 16'h0004, port 1 addr 16'h0008. Required: grants 0,1,0,1; rsp_data_0=32'hA5A50004 and rsp_data_1=32'hA5A50008 on alternating cycles.
- Backpressure: port 1 rsp_ready_1=0 with valid requests continuing. Required: after one response, req_ready_1=0 and rsp_data_1 is held; port 0 is granted every cycle. When rsp_ready_1 rises, port 1 drains and refills in the same cycle.
- Errors: addr 16'h0002 → rsp_err=1, data 32'h0. Addr 16'h1000 → err=1. Addr 16'h0FFC → err=0, data 32'hA5A50FFC.
- Reset mid-stream: assert reset_n=0 while rsp_valid_0=1. Required: rsp_valid_0=0 at once. After release, port 1 alone is granted first if only it is valid; if both are valid, port 0 wins.
